// File: rtl/lsu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_pkg : shared types and constants for the load/store unit
// Rev 1.0
// ------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int c_DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_align : store lane steering, load extraction and fault check
// Rev 1.0
// ------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        fault,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    fault = 1'b0;
    case (st_funct3)
      F3_LH, F3_LHU: fault = st_offset[0];
      F3_LW:         fault = (st_offset != 2'b00);
      F3_LB, F3_LBU: fault = 1'b0;
      default:       fault = 1'b1;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << st_offset;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    w_byte = ld_raw[7:0];
    case (ld_offset)
      2'd0:    w_byte = ld_raw[7:0];
      2'd1:    w_byte = ld_raw[15:8];
      2'd2:    w_byte = ld_raw[23:16];
      default: w_byte = ld_raw[31:24];
    endcase
    w_half = ld_offset[1] ? ld_raw[31:16] : ld_raw[15:0];
  end

  always_comb begin
    ld_data = ld_raw;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  ld_data = {24'd0, w_byte};
      F3_LH:   ld_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  ld_data = {16'd0, w_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_mem_if : core load/store to handshaked data-memory port bridge
// Rev 1.0
// ------------------------------------------------------------------
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        req_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  lsu_state_e          r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                r_we, r_err;
  logic [2:0]          r_funct3;
  logic [1:0]          r_offset;
  logic [29:0]         r_word;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata, r_rdata;

  logic        w_fault, w_start, w_capture, w_timeout, w_last;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata, w_ld_data;

  lsu_align u_align (
    .st_funct3 (req_funct3),
    .st_offset (req_addr[1:0]),
    .st_data   (req_wdata),
    .st_be     (w_st_be),
    .st_wdata  (w_st_wdata),
    .fault     (w_fault),
    .ld_funct3 (r_funct3),
    .ld_offset (r_offset),
    .ld_raw    (mem_rdata),
    .ld_data   (w_ld_data)
  );

  assign w_last = (r_cnt == c_LAST);

  // For a load, a grant alone is progress, not completion, so it cannot
  // rescue the final timeout cycle.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && !w_fault) begin
          w_next  = REQ;
          w_start = 1'b1;
        end
      end
      REQ: begin
        if (mem_gnt && (r_we || mem_rvalid)) begin
          w_next    = DONE;
          w_capture = !r_we;
        end else if (w_last) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end else if (mem_gnt) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_next    = DONE;
          w_capture = 1'b1;
        end else if (w_last) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'd0;
      r_offset <= 2'd0;
      r_word   <= 30'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt    <= '0;
        r_we     <= req_we;
        r_err    <= 1'b0;
        r_funct3 <= req_funct3;
        r_offset <= req_addr[1:0];
        r_word   <= req_addr[31:2];
        r_be     <= w_st_be;
        r_wdata  <= w_st_wdata;
        r_rdata  <= 32'd0;
      end else if (r_state == REQ || r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_capture) begin
        r_rdata <= w_ld_data;
      end
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_rdata <= 32'd0;
      end
    end
  end

  // Reset gates the IDLE term so stall cannot follow req_valid while held in reset.
  assign stall     = ((r_state == IDLE) && req_valid && !w_fault && rst)
                   || (r_state == REQ) || (r_state == WAIT);
  assign req_fault = (r_state == IDLE) && req_valid && w_fault;
  assign mem_req   = (r_state == REQ);
  assign mem_we    = r_we;
  assign mem_addr  = {r_word, 2'b00};
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign rsp_valid = (r_state == DONE);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the core datapath (ALU result as address, rs2 data as store data, funct3 as size) and a handshaked data-memory port.
- Converts each core load/store into a word-aligned bus transaction with byte enables, waits for grant and read data, then returns sign/zero-extended load data to the write-back mux.
- Holds the PC via `stall` while the access is in flight.
- Rejects misaligned or illegal accesses without touching memory.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ+WAIT before the access aborts with `rsp_err`; must be ≥ 1.
- CNT_WIDTH, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address from the ALU.
- req_wdata  in  32  store data (rs2).
- stall  out  1  freeze PC/regfile write this cycle.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load data; valid with `rsp_valid`.
- rsp_err  out  1  timeout abort; valid with `rsp_valid`.
- req_fault  out  1  misaligned address or illegal funct3; combinational.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word-aligned address, with bits [1:0] = 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_gnt  in  1  bus accepted the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (`rst` = 0, immediate):
  - state → IDLE, counter → 0.
  - All registered outputs → 0; `mem_req`, `stall` and `rsp_valid` drop asynchronously.
- Fault check (IDLE only):
  - Fault when H/HU with addr[0] = 1, W with addr[1:0] ≠ 00, or funct3 ∈ {011, 110, 111}.
  - `req_fault` = `req_valid` & fault.
  - No state change, `stall` = 0, no bus activity.
- IDLE:
  - On `req_valid` & !fault: register `we`, `funct3`, `addr[1:0]`, word address, `be` and steered `wdata`; go to REQ.
  - `stall` = 1 combinationally in this same cycle.
- REQ:
  - `mem_req` = 1; `mem_we`/`mem_addr`/`mem_be`/`mem_wdata` held stable from the registers until `mem_gnt`.
  - On `mem_gnt`: a store goes to DONE; a load goes to WAIT.
  - `mem_gnt` & `mem_rvalid` in the same cycle for a load: capture the data and go to DONE directly.
- WAIT:
  - `mem_req` = 0.
  - On `mem_rvalid`: register the extended data and go to DONE.
- Timeout:
  - Counter clears on IDLE→REQ and increments every REQ/WAIT cycle.
  - When counter == TIMEOUT_CYCLES−1 and the completing event is absent: go to DONE with `rsp_err` = 1 and `rsp_rdata` = 0.
  - A completing event in that same cycle wins; no error.
- DONE:
  - `rsp_valid` = 1 and `stall` = 0 for exactly one cycle, then IDLE.
  - `req_valid` is ignored in DONE; the core's next instruction is seen in IDLE.
- `stall` = (IDLE & `req_valid` & !fault) | REQ | WAIT.
- Store steering:
  - SB: `be` = 0001 << a[1:0], `wdata` = byte replicated ×4.
  - SH: `be` = 0011 << a[1:0], `wdata` = half replicated ×2.
  - SW: `be` = 1111.
- Load extraction:
  - Byte lane = `mem_rdata`[8·a +: 8]; half lane = `mem_rdata`[16·a[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Stray `mem_rvalid`/`mem_gnt` in IDLE or DONE: ignored.
- Reset mid-operation abandons the access; a late `mem_rvalid` after reset is ignored.

Decomposition:
- Shared package `lsu_pkg`:
  - State enum.
  - funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - Default TIMEOUT.
- Sub-module `lsu_align` (combinational): store lane steering/`be` generation, load extraction/extension and the fault check.
- The FSM and counter stay in `lsu_mem_if`.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, `mem_gnt` after 2 cycles → `mem_addr` 0x100, `be` 1111, `stall` high 3 cycles, `rsp_valid` one cycle, `rsp_err` 0.
- LB addr 0x103, `mem_rdata` 0x80112233, `rvalid` 1 cycle after `gnt` → `rsp_rdata` 0xFFFFFF80; LBU → 0x00000080.
- SH addr 0x22, wdata 0x0000ABCD → `mem_addr` 0x20, `be` 1100, `mem_wdata` 0xABCDABCD.
- LW addr 0x102 → `req_fault` = 1, `stall` 0, `mem_req` never asserted; funct3 = 011 → same.
- TIMEOUT_CYCLES = 4, load with `mem_gnt` never asserted → DONE after 4 REQ cycles, `rsp_err` = 1, `rsp_rdata` = 0.
- `rst` low during WAIT, then `mem_rvalid` → `mem_req`/`stall` drop immediately, no `rsp_valid`, FSM in IDLE.
